// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed seven-segment display controller. NUM_DISP banks of DIGITS
// digits scan in lockstep. Each digit stays lit for REFRESH_DIV cycles.
// Display data is double-buffered. A load goes into a shadow copy, and the
// shadow copy is promoted to the active copy only on a frame boundary, so a
// partially updated frame is never shown.
//
// Ports
//   i_mclk     system clock, rising edge
//   i_reset    synchronous, active-high reset
//   i_data     hex nibbles; bank b digit d at [(b*DIGITS+d)*4 +: 4]
//   i_dp       decimal-point enable per digit (1 = lit)
//   i_blank    forced blank per digit (1 = dark)
//   i_load     one-cycle strobe that captures i_data/i_dp/i_blank
//   i_lzs      leading-zero suppression enable, sampled live
//   o_seg      per bank {dp,g,f,e,d,c,b,a}, active-low
//   o_an       digit anodes, active-low; bank b at [b*DIGITS +: DIGITS]
//   o_frame    one-cycle pulse after each frame boundary
//   o_pending  shadow data loaded but not yet displayed
//
// Handshake: i_load needs no ready. Every cycle in which i_load is high
// captures the inputs. While o_pending is high, a later load replaces the
// earlier one. A load on the boundary edge itself goes straight to display.
module seg7_scan_ctrl #(
  parameter int NUM_DISP    = 2,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                         i_mclk,
  input  logic                         i_reset,
  input  logic [NUM_DISP*DIGITS*4-1:0] i_data,
  input  logic [NUM_DISP*DIGITS-1:0]   i_dp,
  input  logic [NUM_DISP*DIGITS-1:0]   i_blank,
  input  logic                         i_load,
  input  logic                         i_lzs,
  output logic [NUM_DISP*8-1:0]        o_seg,
  output logic [NUM_DISP*DIGITS-1:0]   o_an,
  output logic                         o_frame,
  output logic                         o_pending
);

  localparam int ND = NUM_DISP * DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [ND*4-1:0]       r_sh_data, r_act_data;
  logic [ND-1:0]         r_sh_dp, r_act_dp;
  logic [ND-1:0]         r_sh_blank, r_act_blank;
  logic                  r_pending;
  logic                  r_frame;
  logic [NUM_DISP*8-1:0] r_seg;
  logic [ND-1:0]         r_an;

  logic                  w_cnt_wrap;
  logic                  w_frame_edge;
  logic [NUM_DISP*8-1:0] w_seg_next;
  logic [ND-1:0]         w_an_next;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, full hex
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    w_cnt_wrap   = (r_cnt == CW'(REFRESH_DIV - 1));
    w_frame_edge = w_cnt_wrap && (r_idx == IW'(DIGITS - 1));
  end

  // Next output values for the digit at r_idx. They are registered, so the
  // pins lag r_idx by one cycle.
  always_comb begin : next_outputs
    logic       zero_above;
    logic       suppress;
    logic [3:0] nib;
    int         pos;
    w_seg_next = '1;
    w_an_next  = '1;
    zero_above = 1'b1;
    suppress   = 1'b0;
    nib        = 4'h0;
    pos        = 0;
    for (int b = 0; b < NUM_DISP; b++) begin
      // The current digit and all digits above it must be zero to suppress it
      zero_above = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
        if (d >= int'(r_idx) && r_act_data[(b*DIGITS+d)*4 +: 4] != 4'h0)
          zero_above = 1'b0;
      end
      pos      = b * DIGITS + int'(r_idx);
      nib      = r_act_data[pos*4 +: 4];
      suppress = i_lzs && (r_idx != '0) && zero_above;
      w_an_next[pos] = 1'b0;
      if (r_act_blank[pos] || suppress)
        w_seg_next[b*8 +: 8] = 8'hFF;
      else
        w_seg_next[b*8 +: 8] = {~r_act_dp[pos], hex7(nib)};
    end
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pending   <= 1'b0;
      r_frame     <= 1'b0;
      r_seg       <= '1;
      r_an        <= '1;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

      if (i_load) begin
        r_sh_data  <= i_data;
        r_sh_dp    <= i_dp;
        r_sh_blank <= i_blank;
      end

      if (w_frame_edge) begin
        r_pending <= 1'b0;
        // A load on the boundary edge bypasses the shadow copy so it is
        // visible in the frame that starts now.
        if (i_load) begin
          r_act_data  <= i_data;
          r_act_dp    <= i_dp;
          r_act_blank <= i_blank;
        end else if (r_pending) begin
          r_act_data  <= r_sh_data;
          r_act_dp    <= r_sh_dp;
          r_act_blank <= r_sh_blank;
        end
      end else if (i_load) begin
        r_pending <= 1'b1;
      end

      r_frame <= w_frame_edge;
      r_seg   <= w_seg_next;
      r_an    <= w_an_next;
    end
  end

  assign o_seg     = r_seg;
  assign o_an      = r_an;
  assign o_frame   = r_frame;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        i_mclk = 1'b0;
  logic        i_reset;
  logic [31:0] i_data;
  logic [7:0]  i_dp;
  logic [7:0]  i_blank;
  logic        i_load;
  logic        i_lzs;
  logic [15:0] o_seg;
  logic [7:0]  o_an;
  logic        o_frame;
  logic        o_pending;

  int pass_n  = 0;
  int total_n = 0;
  int edge_n  = 0;   // rising edges since reset release

  seg7_scan_ctrl #(.NUM_DISP(2), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .i_mclk(i_mclk), .i_reset(i_reset), .i_data(i_data), .i_dp(i_dp),
    .i_blank(i_blank), .i_load(i_load), .i_lzs(i_lzs), .o_seg(o_seg),
    .o_an(o_an), .o_frame(o_frame), .o_pending(o_pending)
  );

  // clock / reset
  always #5 i_mclk = ~i_mclk;

  // One rising edge; returns at the following falling edge for sampling/driving
  task automatic tick();
    @(posedge i_mclk);
    edge_n++;
    @(negedge i_mclk);
  endtask

  // Digit whose value is on the pins after rising edge k (k >= 1)
  function automatic int dig_of(int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [7:0] an_of(int k);
    logic [3:0] a;
    a = ~(4'b0001 << dig_of(k));
    return {a, a};
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_data = '0; i_dp = '0; i_blank = '0; i_load = 1'b0; i_lzs = 1'b0;
    tick(); tick();
    total_n++; if (o_an !== 8'hFF) $display("FAIL reset_an got %h exp ff", o_an); else pass_n++;
    total_n++; if (o_seg !== 16'hFFFF) $display("FAIL reset_seg got %h exp ffff", o_seg); else pass_n++;
    total_n++; if (o_frame !== 1'b0) $display("FAIL reset_frame got %b exp 0", o_frame); else pass_n++;
    total_n++; if (o_pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", o_pending); else pass_n++;
    i_reset = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_scan();
    for (int k = 1; k <= 32; k++) begin
      tick();
      total_n++; if (o_an !== an_of(k)) $display("FAIL scan_an k=%0d got %h exp %h", k, o_an, an_of(k)); else pass_n++;
      total_n++; if (o_seg !== 16'hC0C0) $display("FAIL scan_seg k=%0d got %h exp c0c0", k, o_seg); else pass_n++;
      total_n++; if (o_frame !== (k % 16 == 0)) $display("FAIL scan_frame k=%0d got %b", k, o_frame); else pass_n++;
    end
  endtask

  // Mid-frame load, shown from the next frame
  task automatic test_load();
    logic [15:0] exp_tab [4];
    logic [15:0] e;
    exp_tab[0] = 16'h8EB0; exp_tab[1] = 16'h80A4; exp_tab[2] = 16'h88F9; exp_tab[3] = 16'hF9C0;
    for (int k = 33; k <= 64; k++) begin
      if (k == 38) begin i_data = 32'h1A8F_0123; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
      e = (k <= 48) ? 16'hC0C0 : exp_tab[dig_of(k)];
      total_n++; if (o_seg !== e) $display("FAIL load_seg k=%0d got %h exp %h", k, o_seg, e); else pass_n++;
      total_n++; if (o_pending !== (k >= 38 && k < 48)) $display("FAIL load_pending k=%0d got %b", k, o_pending); else pass_n++;
      total_n++; if (o_an !== an_of(k)) $display("FAIL load_an k=%0d got %h exp %h", k, o_an, an_of(k)); else pass_n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] old_tab [4];
    logic [15:0] e;
    old_tab[0] = 16'h8EB0; old_tab[1] = 16'h80A4; old_tab[2] = 16'h88F9; old_tab[3] = 16'hF9C0;
    for (int k = 65; k <= 96; k++) begin
      if (k == 67) begin i_data = 32'h1111_1111; i_load = 1'b1; end
      if (k == 71) begin i_data = 32'h2222_2222; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
      e = (k <= 80) ? old_tab[dig_of(k)] : 16'hA4A4;
      total_n++; if (o_seg !== e) $display("FAIL b2b_seg k=%0d got %h exp %h", k, o_seg, e); else pass_n++;
      total_n++; if (o_pending !== (k >= 67 && k < 80)) $display("FAIL b2b_pending k=%0d got %b", k, o_pending); else pass_n++;
    end
  endtask

  task automatic test_load_on_boundary();
    logic [15:0] exp_tab [4];
    logic [15:0] e;
    exp_tab[0] = 16'h82C6; exp_tab[1] = 16'hF8A1; exp_tab[2] = 16'h8086; exp_tab[3] = 16'h908E;
    for (int k = 97; k <= 128; k++) begin
      if (k == 112) begin i_data = 32'h9876_FEDC; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
      e = (k <= 112) ? 16'hA4A4 : exp_tab[dig_of(k)];
      total_n++; if (o_seg !== e) $display("FAIL bnd_seg k=%0d got %h exp %h", k, o_seg, e); else pass_n++;
      total_n++; if (o_pending !== 1'b0) $display("FAIL bnd_pending k=%0d got %b exp 0", k, o_pending); else pass_n++;
      total_n++; if (o_frame !== (k % 16 == 0)) $display("FAIL bnd_frame k=%0d got %b", k, o_frame); else pass_n++;
    end
  endtask

  task automatic test_lzs();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'hC0C0; exp_tab[1] = 16'hFF92; exp_tab[2] = 16'hFFFF; exp_tab[3] = 16'hFFFF;
    i_lzs = 1'b1;
    for (int k = 129; k <= 160; k++) begin
      if (k == 131) begin i_data = 32'h0000_0050; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
      if (k > 144) begin
        total_n++; if (o_seg !== exp_tab[dig_of(k)]) $display("FAIL lzs_seg k=%0d got %h exp %h", k, o_seg, exp_tab[dig_of(k)]); else pass_n++;
        total_n++; if (o_an !== an_of(k)) $display("FAIL lzs_an k=%0d got %h exp %h", k, o_an, an_of(k)); else pass_n++;
      end
    end
    i_lzs = 1'b0;
  endtask

  task automatic test_dp_blank();
    logic [15:0] old_tab [4];
    logic [15:0] exp_tab [4];
    logic [15:0] e;
    // Previous data 0000_0050 with suppression now off
    old_tab[0] = 16'hC0C0; old_tab[1] = 16'hC092; old_tab[2] = 16'hC0C0; old_tab[3] = 16'hC0C0;
    exp_tab[0] = 16'hC040; exp_tab[1] = 16'hC0FF; exp_tab[2] = 16'hC0C0; exp_tab[3] = 16'hC0C0;
    for (int k = 161; k <= 192; k++) begin
      if (k == 163) begin i_data = 32'h0; i_dp = 8'h01; i_blank = 8'h02; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
      e = (k <= 176) ? old_tab[dig_of(k)] : exp_tab[dig_of(k)];
      total_n++; if (o_seg !== e) $display("FAIL dpblank_seg k=%0d got %h exp %h", k, o_seg, e); else pass_n++;
      total_n++; if (o_an !== an_of(k)) $display("FAIL dpblank_an k=%0d got %h exp %h", k, o_an, an_of(k)); else pass_n++;
    end
  endtask

  task automatic test_reset_mid_pending();
    for (int k = 193; k <= 200; k++) begin
      if (k == 196) begin i_data = 32'h1234_5678; i_dp = 8'hFF; i_blank = 8'h00; i_load = 1'b1; end
      tick();
      i_load = 1'b0;
    end
    total_n++; if (o_pending !== 1'b1) $display("FAIL rstp_pre_pending got %b exp 1", o_pending); else pass_n++;
    i_reset = 1'b1;
    tick();
    total_n++; if (o_pending !== 1'b0) $display("FAIL rstp_pending got %b exp 0", o_pending); else pass_n++;
    total_n++; if (o_an !== 8'hFF) $display("FAIL rstp_an got %h exp ff", o_an); else pass_n++;
    total_n++; if (o_seg !== 16'hFFFF) $display("FAIL rstp_seg got %h exp ffff", o_seg); else pass_n++;
    total_n++; if (o_frame !== 1'b0) $display("FAIL rstp_frame got %b exp 0", o_frame); else pass_n++;
    i_reset = 1'b0;
    edge_n = 0;
    // Discarded data must never appear after the reset
    for (int k = 1; k <= 32; k++) begin
      tick();
      total_n++; if (o_an !== an_of(k)) $display("FAIL rstp_scan_an k=%0d got %h exp %h", k, o_an, an_of(k)); else pass_n++;
      total_n++; if (o_seg !== 16'hC0C0) $display("FAIL rstp_scan_seg k=%0d got %h exp c0c0", k, o_seg); else pass_n++;
      total_n++; if (o_pending !== 1'b0) $display("FAIL rstp_scan_pending k=%0d got %b exp 0", k, o_pending); else pass_n++;
      total_n++; if (o_frame !== (k % 16 == 0)) $display("FAIL rstp_scan_frame k=%0d got %b", k, o_frame); else pass_n++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_load_on_boundary();
    test_lzs();
    test_dp_blank();
    test_reset_mid_pending();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
